// File: rtl/score_keeper_if.sv
// ---------------------------------------------------------------------------
// score_keeper_if
// Bundles the score_keeper's match-control signals so that the hit detector,
// the frame timing source and the movement blocks can connect as one group.
//
// Signals (direction as seen by the score_keeper, i.e. the slave side):
//   startOfFrame  in   one-cycle pulse per video frame
//   new_game      in   level from key; rising edge starts/restarts a match
//   goal_left     in   ball in gate 1 (goal for player 2), level
//   goal_right    in   ball in gate 2 (goal for player 1), level
//   doubleball    in   ball over bonus object, level
//   score1        out  player 1 score (4 bits)
//   score2        out  player 2 score (4 bits)
//   freeze        out  ball and players hold position
//   ball_reset    out  one-cycle pulse, ball back to centre serve position
//   game_over     out  high while the match is over
//   winner        out  01 = player 1, 10 = player 2, 00 = none
//   bonus_armed   out  next credited goal is worth 2 points
//
// Modports:
//   master  the side that drives the detector flags and reads the results
//   slave   the score_keeper itself
// ---------------------------------------------------------------------------
interface score_keeper_if;
  logic       startOfFrame;
  logic       new_game;
  logic       goal_left;
  logic       goal_right;
  logic       doubleball;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       freeze;
  logic       ball_reset;
  logic       game_over;
  logic [1:0] winner;
  logic       bonus_armed;

  modport master (
    output startOfFrame, new_game, goal_left, goal_right, doubleball,
    input  score1, score2, freeze, ball_reset, game_over, winner, bonus_armed
  );

  modport slave (
    input  startOfFrame, new_game, goal_left, goal_right, doubleball,
    output score1, score2, freeze, ball_reset, game_over, winner, bonus_armed
  );
endinterface

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Match controller downstream of the ball/player hit detector. Turns the
// detector's level flags into single scoring events, keeps both scores and
// sequences the match through IDLE -> PLAY -> PAUSE -> ... -> OVER, driving
// the freeze and ball_reset controls used by the movement blocks.
//
// Parameters:
//   WIN_SCORE     score that ends the match (1..15)
//   PAUSE_FRAMES  frames frozen after a goal (1..255)
//
// Ports:
//   CLK     system clock
//   RESETn  asynchronous, active-low reset
//   io_sk   score_keeper_if.slave, carries all match inputs and outputs
//
// Optional feature:
//   DOUBLE_POINTS_EN  when defined, a doubleball edge in PLAY arms a bonus
//                     that makes the next credited goal worth 2 points.
//                     When undefined, doubleball is ignored and bonus_armed
//                     stays 0.
// ---------------------------------------------------------------------------
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60
) (
  input logic           CLK,
  input logic           RESETn,
  score_keeper_if.slave io_sk
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    OVER
  } state_t;

  localparam logic [4:0] WIN5    = 5'(WIN_SCORE);
  localparam logic [3:0] WIN4    = 4'(WIN_SCORE);
  localparam logic [7:0] PF_LAST = 8'(PAUSE_FRAMES - 1);

  // Input sample flops and their one-cycle-delayed copies for edge detection
  logic r_sofS;
  logic r_newS, r_newP;
  logic r_glS,  r_glP;
  logic r_grS,  r_grP;

  // Match state and registered outputs
  state_t     r_state;
  logic [3:0] r_score1;
  logic [3:0] r_score2;
  logic [7:0] r_cnt;
  logic [1:0] r_winner;
  logic       r_bonus;
  logic       r_freeze;
  logic       r_ballReset;
  logic       r_gameOver;

  // Next-state values produced by the combinational process
  state_t     w_stateNext;
  logic [3:0] w_score1Next;
  logic [3:0] w_score2Next;
  logic [7:0] w_cntNext;
  logic [1:0] w_winnerNext;
  logic       w_bonusNext;
  logic       w_ballResetNext;

  logic       w_newEdge;
  logic       w_glEdge;
  logic       w_grEdge;
  logic       w_dbEdge;
  logic [4:0] w_points;
  logic [4:0] w_sum1;
  logic [4:0] w_sum2;

  assign w_newEdge = r_newS & ~r_newP;
  assign w_glEdge  = r_glS  & ~r_glP;
  assign w_grEdge  = r_grS  & ~r_grP;

  // Sums are one bit wider than the score so a 2-point goal near the top
  // cannot wrap before the clamp against WIN_SCORE.
  assign w_points = r_bonus ? 5'd2 : 5'd1;
  assign w_sum1   = {1'b0, r_score1} + w_points;
  assign w_sum2   = {1'b0, r_score2} + w_points;

`ifdef DOUBLE_POINTS_EN
  logic r_dbS, r_dbP;

  // Bonus object flag is sampled and edge-detected like the goal flags
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_dbS <= 1'b0;
      r_dbP <= 1'b0;
    end else begin
      r_dbS <= io_sk.doubleball;
      r_dbP <= r_dbS;
    end
  end

  assign w_dbEdge = r_dbS & ~r_dbP;
`else
  assign w_dbEdge = 1'b0;
`endif

  // Sample every input once and keep the previous sample; the flops keep
  // tracking in every state so a level already high when PLAY is entered
  // never looks like a fresh edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sofS <= 1'b0;
      r_newS <= 1'b0;
      r_newP <= 1'b0;
      r_glS  <= 1'b0;
      r_glP  <= 1'b0;
      r_grS  <= 1'b0;
      r_grP  <= 1'b0;
    end else begin
      r_sofS <= io_sk.startOfFrame;
      r_newS <= io_sk.new_game;
      r_newP <= r_newS;
      r_glS  <= io_sk.goal_left;
      r_glP  <= r_glS;
      r_grS  <= io_sk.goal_right;
      r_grP  <= r_grS;
    end
  end

  // State and output registers; freeze and game_over are decoded from the
  // next state so they change on the same edge as the state itself.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= IDLE;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_cnt       <= 8'd0;
      r_winner    <= 2'b00;
      r_bonus     <= 1'b0;
      r_freeze    <= 1'b1;
      r_ballReset <= 1'b0;
      r_gameOver  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_score1    <= w_score1Next;
      r_score2    <= w_score2Next;
      r_cnt       <= w_cntNext;
      r_winner    <= w_winnerNext;
      r_bonus     <= w_bonusNext;
      r_freeze    <= (w_stateNext != PLAY);
      r_ballReset <= w_ballResetNext;
      r_gameOver  <= (w_stateNext == OVER);
    end
  end

  // Next-state logic. A new_game edge overrides everything else, including a
  // goal edge in the same cycle. In PLAY, player 1 wins a simultaneous goal
  // tie, and a goal that reaches WIN_SCORE is clamped and ends the match.
  always_comb begin
    w_stateNext     = r_state;
    w_score1Next    = r_score1;
    w_score2Next    = r_score2;
    w_cntNext       = r_cnt;
    w_winnerNext    = r_winner;
    w_bonusNext     = r_bonus;
    w_ballResetNext = 1'b0;

    if (w_newEdge) begin
      w_stateNext     = PLAY;
      w_score1Next    = 4'd0;
      w_score2Next    = 4'd0;
      w_cntNext       = 8'd0;
      w_winnerNext    = 2'b00;
      w_bonusNext     = 1'b0;
      w_ballResetNext = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
        end

        PLAY: begin
          if (w_grEdge) begin
            w_bonusNext = 1'b0;
            if (w_sum1 >= WIN5) begin
              w_score1Next = WIN4;
              w_winnerNext = 2'b01;
              w_stateNext  = OVER;
            end else begin
              w_score1Next = w_sum1[3:0];
              w_cntNext    = 8'd0;
              w_stateNext  = PAUSE;
            end
          end else if (w_glEdge) begin
            w_bonusNext = 1'b0;
            if (w_sum2 >= WIN5) begin
              w_score2Next = WIN4;
              w_winnerNext = 2'b10;
              w_stateNext  = OVER;
            end else begin
              w_score2Next = w_sum2[3:0];
              w_cntNext    = 8'd0;
              w_stateNext  = PAUSE;
            end
          end else if (w_dbEdge) begin
            w_bonusNext = 1'b1;
          end
        end

        PAUSE: begin
          // Each startOfFrame is a single-cycle pulse, so its sampled level
          // marks exactly one frame.
          if (r_sofS) begin
            if (r_cnt == PF_LAST) begin
              w_stateNext     = PLAY;
              w_ballResetNext = 1'b1;
            end else begin
              w_cntNext = r_cnt + 8'd1;
            end
          end
        end

        OVER: begin
        end

        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  assign io_sk.score1      = r_score1;
  assign io_sk.score2      = r_score2;
  assign io_sk.freeze      = r_freeze;
  assign io_sk.ball_reset  = r_ballReset;
  assign io_sk.game_over   = r_gameOver;
  assign io_sk.winner      = r_winner;
  assign io_sk.bonus_armed = r_bonus;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
// Directed bench for score_keeper built with WIN_SCORE=2 and PAUSE_FRAMES=3.
// Walks a match through serve, goal, pause, simultaneous goals, game over,
// restart, bonus handling (both builds of DOUBLE_POINTS_EN) and an
// asynchronous reset during a pause.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_score_keeper;

  logic CLK;
  logic RESETn;
  int   total;
  int   bad;

  score_keeper_if sk ();

  score_keeper #(
    .WIN_SCORE   (2),
    .PAUSE_FRAMES(3)
  ) dut (
    .CLK   (CLK),
    .RESETn(RESETn),
    .io_sk (sk)
  );

  // 100 MHz clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all detector/key inputs at once
  task automatic applyStimulus(input logic ng, input logic gl, input logic gr,
                               input logic db, input logic sof);
    sk.new_game     = ng;
    sk.goal_left    = gl;
    sk.goal_right   = gr;
    sk.doubleball   = db;
    sk.startOfFrame = sof;
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Three startOfFrame pulses; checks that the serve happens one clock after
  // the third pulse is sampled and not before. Other inputs are kept.
  task automatic pauseOut(input string tag);
    for (int p = 0; p < 2; p++) begin
      sk.startOfFrame = 1'b1;
      tick(1);
      sk.startOfFrame = 1'b0;
      tick(1);
    end
    sk.startOfFrame = 1'b1;
    tick(1);
    checkOutput({tag, "_br_early"}, 8'(sk.ball_reset), 8'd0);
    checkOutput({tag, "_frz_hold"}, 8'(sk.freeze), 8'd1);
    sk.startOfFrame = 1'b0;
    tick(1);
    checkOutput({tag, "_br_pulse"}, 8'(sk.ball_reset), 8'd1);
    checkOutput({tag, "_frz_rel"}, 8'(sk.freeze), 8'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    RESETn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    #12;
    checkOutput("rst_score1", 8'(sk.score1), 8'd0);
    checkOutput("rst_score2", 8'(sk.score2), 8'd0);
    checkOutput("rst_freeze", 8'(sk.freeze), 8'd1);
    checkOutput("rst_ballrst", 8'(sk.ball_reset), 8'd0);
    checkOutput("rst_gameover", 8'(sk.game_over), 8'd0);
    checkOutput("rst_winner", 8'(sk.winner), 8'd0);
    checkOutput("rst_bonus", 8'(sk.bonus_armed), 8'd0);
    tick(1);
    RESETn = 1'b1;
    tick(2);
    checkOutput("idle_freeze", 8'(sk.freeze), 8'd1);

    // Serve: freeze drops two clocks after the new_game edge
    applyStimulus(1, 0, 0, 0, 0);
    tick(1);
    checkOutput("serve_frz_n1", 8'(sk.freeze), 8'd1);
    tick(1);
    checkOutput("serve_frz_n2", 8'(sk.freeze), 8'd0);
    checkOutput("serve_br", 8'(sk.ball_reset), 8'd1);
    checkOutput("serve_s1", 8'(sk.score1), 8'd0);
    checkOutput("serve_s2", 8'(sk.score2), 8'd0);
    tick(1);
    checkOutput("serve_br_off", 8'(sk.ball_reset), 8'd0);
    applyStimulus(0, 0, 0, 0, 0);

    // Held goal_right scores exactly once, including after the pause ends
    applyStimulus(0, 0, 1, 0, 0);
    tick(2);
    checkOutput("hold_s1", 8'(sk.score1), 8'd1);
    checkOutput("hold_frz", 8'(sk.freeze), 8'd1);
    tick(500);
    checkOutput("hold_s1_500", 8'(sk.score1), 8'd1);
    checkOutput("hold_go", 8'(sk.game_over), 8'd0);
    pauseOut("p1");
    tick(5);
    checkOutput("hold_s1_play", 8'(sk.score1), 8'd1);
    checkOutput("hold_frz_play", 8'(sk.freeze), 8'd0);
    applyStimulus(0, 0, 0, 0, 0);

    // Restart, then both goals in the same cycle: only player 1 credited
    applyStimulus(1, 0, 0, 0, 0);
    tick(2);
    checkOutput("rs1_s1", 8'(sk.score1), 8'd0);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(0, 1, 1, 0, 0);
    tick(2);
    checkOutput("both_s1", 8'(sk.score1), 8'd1);
    checkOutput("both_s2", 8'(sk.score2), 8'd0);
    applyStimulus(0, 0, 0, 0, 0);

    // Restart from PAUSE, then player 2 wins 2-0
    applyStimulus(1, 0, 0, 0, 0);
    tick(2);
    checkOutput("rs2_s1", 8'(sk.score1), 8'd0);
    checkOutput("rs2_br", 8'(sk.ball_reset), 8'd1);
    applyStimulus(0, 1, 0, 0, 0);
    tick(2);
    checkOutput("p2g1_s2", 8'(sk.score2), 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    pauseOut("p2");
    applyStimulus(0, 1, 0, 0, 0);
    tick(2);
    checkOutput("win2_s2", 8'(sk.score2), 8'd2);
    checkOutput("win2_go", 8'(sk.game_over), 8'd1);
    checkOutput("win2_winner", 8'(sk.winner), 8'b10);
    checkOutput("win2_frz", 8'(sk.freeze), 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(0, 1, 1, 0, 0);
    tick(3);
    checkOutput("over_s2", 8'(sk.score2), 8'd2);
    checkOutput("over_s1", 8'(sk.score1), 8'd0);
    checkOutput("over_go", 8'(sk.game_over), 8'd1);
    applyStimulus(1, 0, 0, 0, 0);
    tick(2);
    checkOutput("rs3_s2", 8'(sk.score2), 8'd0);
    checkOutput("rs3_winner", 8'(sk.winner), 8'd0);
    checkOutput("rs3_go", 8'(sk.game_over), 8'd0);
    checkOutput("rs3_frz", 8'(sk.freeze), 8'd0);
    applyStimulus(0, 0, 0, 0, 0);

    // Bonus: player 1 at 1, doubleball edge, then a goal ends the match
    applyStimulus(0, 0, 1, 0, 0);
    tick(2);
    checkOutput("b_s1", 8'(sk.score1), 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    pauseOut("p3");
    applyStimulus(0, 0, 0, 1, 0);
    tick(2);
`ifdef DOUBLE_POINTS_EN
    checkOutput("b_armed", 8'(sk.bonus_armed), 8'd1);
`else
    checkOutput("b_armed", 8'(sk.bonus_armed), 8'd0);
`endif
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0, 1, 0);
    tick(2);
`ifdef DOUBLE_POINTS_EN
    checkOutput("b_armed2", 8'(sk.bonus_armed), 8'd1);
`else
    checkOutput("b_armed2", 8'(sk.bonus_armed), 8'd0);
`endif
    checkOutput("b_frz", 8'(sk.freeze), 8'd0);
    applyStimulus(0, 0, 1, 0, 0);
    tick(2);
    checkOutput("b_s1_final", 8'(sk.score1), 8'd2);
    checkOutput("b_clear", 8'(sk.bonus_armed), 8'd0);
    checkOutput("b_go", 8'(sk.game_over), 8'd1);
    checkOutput("b_winner", 8'(sk.winner), 8'b01);
    applyStimulus(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a pause
    applyStimulus(1, 0, 0, 0, 0);
    tick(2);
    applyStimulus(0, 0, 1, 0, 0);
    tick(2);
    checkOutput("ar_s1", 8'(sk.score1), 8'd1);
    checkOutput("ar_frz", 8'(sk.freeze), 8'd1);
    #2;
    RESETn = 1'b0;
    #1;
    checkOutput("ar_rst_s1", 8'(sk.score1), 8'd0);
    checkOutput("ar_rst_s2", 8'(sk.score2), 8'd0);
    checkOutput("ar_rst_frz", 8'(sk.freeze), 8'd1);
    checkOutput("ar_rst_br", 8'(sk.ball_reset), 8'd0);
    checkOutput("ar_rst_go", 8'(sk.game_over), 8'd0);
    checkOutput("ar_rst_win", 8'(sk.winner), 8'd0);
    checkOutput("ar_rst_bonus", 8'(sk.bonus_armed), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match controller that sits directly downstream of the ball/player hit detector. It turns the detector's level-type `goal_left`, `goal_right` and `doubleball` flags into single scoring events and keeps both players' scores. It sequences the match through serve, post-goal pause and game-over, and drives the freeze and ball-reset controls consumed by the ball and player movement blocks.

## Interface
Parameters:
- `WIN_SCORE`, default 7: score that ends the match; legal range 1..15.
- `PAUSE_FRAMES`, default 60: frames frozen after a goal; legal range 1..255.

Ports:
- `CLK`  in  1  system clock.
- `RESETn`  in  1  reset; asynchronous, active-low.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `new_game`  in  1  level from key; rising edge starts or restarts a match.
- `goal_left`  in  1  ball overlaps gate 1; goal for player 2; level, may stay high many cycles.
- `goal_right`  in  1  ball overlaps gate 2; goal for player 1; level.
- `doubleball`  in  1  ball overlaps bonus object; level.
- `score1`  out  4  player 1 score.
- `score2`  out  4  player 2 score.
- `freeze`  out  1  high means ball and players must hold position.
- `ball_reset`  out  1  one-cycle pulse; ball returns to centre serve position.
- `game_over`  out  1  high while in OVER.
- `winner`  out  2  01 = player 1, 10 = player 2, 00 = none.
- `bonus_armed`  out  1  next goal is worth 2 points.

## Operation
- All inputs are sampled into flops. Events are rising edges only: current sample 1, previous sample 0. A held level never scores twice.
- FSM states are IDLE, PLAY, PAUSE and OVER.
- IDLE (reset state): `freeze`=1, both scores 0.
  - `new_game` edge -> PLAY, with a `ball_reset` pulse.
- PLAY: `freeze`=0.
  - `goal_right` edge: `score1` += points, then go to PAUSE.
  - `goal_left` edge: `score2` += points, then go to PAUSE.
  - If both edges arrive in the same cycle, only player 1 is credited.
  - points is 1 normally, or 2 when bonus is armed (see Configuration).
  - If the updated score is >= `WIN_SCORE`: the score is clamped to `WIN_SCORE`, the FSM goes to OVER instead of PAUSE, and `winner` is set.
- PAUSE: `freeze`=1. An 8-bit counter is cleared on entry and counts `startOfFrame` pulses.
  - After the `PAUSE_FRAMES`-th pulse -> PLAY, with a `ball_reset` pulse.
  - Goal and doubleball edges are ignored in this state.
- OVER: `freeze`=1, `game_over`=1, `winner` held. All goal inputs are ignored.
- `new_game` edge in any state other than IDLE: scores cleared, bonus cleared, counter cleared, `winner`=00, go to PLAY with a `ball_reset` pulse. This takes priority over a goal edge in the same cycle.

## Timing
- Reset values: `score1`=0, `score2`=0, `freeze`=1, `ball_reset`=0, `game_over`=0, `winner`=00, `bonus_armed`=0. The FSM resets to IDLE and all edge-detect flops reset to 0.
- Input change at edge N is sampled at N. The event is detected and the score, state and outputs update at edge N+1, so latency is 2 clocks from input to output.
- `ball_reset` is high for exactly one cycle, in the same cycle the FSM enters PLAY.
- PAUSE exit is one clock after the `PAUSE_FRAMES`-th sampled `startOfFrame`.
- An input already high when PLAY is entered does not count; the flops still track it during PAUSE and OVER.
- Reset asserted mid-match returns to the reset values immediately, without waiting for a clock.
- All outputs are registered.

## Configuration
- `DOUBLE_POINTS_EN` defined:
  - A `doubleball` edge in PLAY sets the bonus flag; `bonus_armed` mirrors it.
  - The next credited goal adds 2 points (still clamped to `WIN_SCORE`) and clears the flag.
  - A second `doubleball` edge while the flag is set has no further effect.
- `DOUBLE_POINTS_EN` not defined:
  - The `doubleball` input is ignored, `bonus_armed` is tied 0, and every goal adds 1.

## Test plan
- Reset, then pulse `new_game`: `freeze` goes 1 -> 0 two clocks after the edge, `ball_reset` pulses once, scores read 0/0.
- Hold `goal_right` high for 500 cycles in PLAY: `score1`=1 exactly, FSM in PAUSE, `freeze`=1. With `PAUSE_FRAMES`=3, `ball_reset` pulses one clock after the 3rd `startOfFrame`.
- Assert `goal_left` and `goal_right` rising in the same cycle: `score1`=1, `score2`=0.
- `WIN_SCORE`=2, two goals for player 2: `score2`=2, `game_over`=1, `winner`=10. A further goal edge leaves the score unchanged. Then `new_game` gives 0/0, `winner`=00, PLAY.
- With `DOUBLE_POINTS_EN`, `WIN_SCORE`=7, `score1`=6: a `doubleball` edge sets `bonus_armed`=1. The following `goal_right` gives `score1`=7 (clamped), `bonus_armed`=0, OVER.
- Assert `RESETn` low during PAUSE with `score1`=3: all outputs return to reset values without a clock edge.
